// File: rtl/lcd_receiver.sv
// lcd_receiver: serial LCD-style byte receiver.
// Samples an asynchronous chip-select / register-select / serial-clock /
// serial-data bus, assembles bytes MSB first and hands each completed byte
// to a consumer through a valid/ack holding register.
module lcd_receiver #(
  parameter logic CS_ACTIVE = 1'b0,
  parameter logic CMD_RS    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       I_cs1,
  input  logic       I_rs,
  input  logic       I_sclk,
  input  logic       I_sid,
  input  logic       I_ack,
  output logic       O_valid,
  output logic [7:0] O_data,
  output logic       O_is_cmd,
  output logic [1:0] O_status,
  output logic       O_overrun,
  output logic       O_frame_err
);

  typedef enum logic [1:0] {
    READY   = 2'b00,
    RECEIVE = 2'b01,
    FINISH  = 2'b10
  } state_t;

  state_t      state;

  logic [1:0]  cs_sync;
  logic [1:0]  rs_sync;
  logic [1:0]  sclk_sync;
  logic [1:0]  sid_sync;

  logic        sclk_prev;
  logic        sclk_rise;
  logic        sid_d;
  logic        rs_d;

  // Only the first seven bits need storing; the eighth arrives with the
  // completing edge and goes straight into O_data.
  logic [6:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic        cs_active;

  assign cs_active = (cs_sync[1] == CS_ACTIVE);
  assign O_status  = state;

  // Two-flop synchronizers for every asynchronous bus line.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= 2'b00;
      rs_sync   <= 2'b00;
      sclk_sync <= 2'b00;
      sid_sync  <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[0],   I_cs1};
      rs_sync   <= {rs_sync[0],   I_rs};
      sclk_sync <= {sclk_sync[0], I_sclk};
      sid_sync  <= {sid_sync[0],  I_sid};
    end
  end

  // Registered sclk rising-edge detect; sid and rs are delayed alongside so
  // the FSM sees the data values from the same instant as the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev <= 1'b0;
      sclk_rise <= 1'b0;
      sid_d     <= 1'b0;
      rs_d      <= 1'b0;
    end else begin
      sclk_prev <= sclk_sync[1];
      sclk_rise <= sclk_sync[1] & ~sclk_prev;
      sid_d     <= sid_sync[1];
      rs_d      <= rs_sync[1];
    end
  end

  // Frame FSM with byte assembly, hand-off register and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= READY;
      shift_reg   <= 7'h00;
      bit_cnt     <= 3'd0;
      O_valid     <= 1'b0;
      O_data      <= 8'h00;
      O_is_cmd    <= 1'b0;
      O_overrun   <= 1'b0;
      O_frame_err <= 1'b0;
    end else begin
      O_overrun   <= 1'b0;
      O_frame_err <= 1'b0;
      if (O_valid && I_ack) begin
        O_valid <= 1'b0;
      end
      case (state)
        READY: begin
          if (cs_active) begin
            state   <= RECEIVE;
            bit_cnt <= 3'd0;
          end
        end
        RECEIVE, FINISH: begin
          if (!cs_active) begin
            state   <= READY;
            bit_cnt <= 3'd0;
            if (bit_cnt != 3'd0) begin
              O_frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[5:0], sid_d};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= FINISH;
              if (!O_valid || I_ack) begin
                O_data   <= {shift_reg, sid_d};
                O_is_cmd <= (rs_d == CMD_RS);
                O_valid  <= 1'b1;
              end else begin
                O_overrun <= 1'b1;
              end
            end else begin
              state <= RECEIVE;
            end
          end else begin
            state <= RECEIVE;
          end
        end
        default: begin
          state <= READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_receiver.sv
// tb_lcd_receiver: directed self-checking bench for lcd_receiver.
module tb_lcd_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       I_cs1;
  logic       I_rs;
  logic       I_sclk;
  logic       I_sid;
  logic       I_ack;
  logic       O_valid;
  logic [7:0] O_data;
  logic       O_is_cmd;
  logic [1:0] O_status;
  logic       O_overrun;
  logic       O_frame_err;

  int assert_count    = 0;
  int fail_count      = 0;
  int overrun_count   = 0;
  int frame_err_count = 0;
  int snap;

  lcd_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .I_cs1      (I_cs1),
    .I_rs       (I_rs),
    .I_sclk     (I_sclk),
    .I_sid      (I_sid),
    .I_ack      (I_ack),
    .O_valid    (O_valid),
    .O_data     (O_data),
    .O_is_cmd   (O_is_cmd),
    .O_status   (O_status),
    .O_overrun  (O_overrun),
    .O_frame_err(O_frame_err)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Pulse counters, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (O_overrun)   overrun_count++;
    if (O_frame_err) frame_err_count++;
  end

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One serial bit: sid set up 3 clocks before the sclk rise, held high 3 clocks.
  task applyStimulus(input logic b);
    I_sid = b;
    step(3);
    I_sclk = 1'b1;
    step(3);
    I_sclk = 1'b0;
  endtask

  task send_bits(input logic [7:0] value, input int count);
    for (int i = 0; i < count; i++) begin
      applyStimulus(value[7-i]);
    end
  endtask

  // Full byte, ending on the FINISH cycle; optional ack sampled on that cycle.
  task receive_byte(input logic [7:0] value, input logic ack_on_finish);
    send_bits(value, 8);
    I_ack = ack_on_finish;
    step(1);
    I_ack = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    I_cs1  = 1'b1;
    I_rs   = 1'b0;
    I_sclk = 1'b0;
    I_sid  = 1'b0;
    I_ack  = 1'b0;
    step(3);
    checkOutput("reset_status", O_status, 2'b00);
    checkOutput("reset_valid", O_valid, 1'b0);
    checkOutput("reset_data", O_data, 8'h00);
    checkOutput("reset_is_cmd", O_is_cmd, 1'b0);
    checkOutput("reset_overrun", O_overrun, 1'b0);
    checkOutput("reset_frame_err", O_frame_err, 1'b0);
    rst = 1'b0;
    step(3);
    checkOutput("idle_status", O_status, 2'b00);

    // Command byte 0x2c with exact latency check.
    I_cs1 = 1'b0;
    step(4);
    checkOutput("frame_open_status", O_status, 2'b01);
    send_bits(8'h2c, 8);
    checkOutput("cmd_valid_before_latency", O_valid, 1'b0);
    checkOutput("cmd_status_before_latency", O_status, 2'b01);
    step(1);
    checkOutput("cmd_valid", O_valid, 1'b1);
    checkOutput("cmd_data", O_data, 8'h2c);
    checkOutput("cmd_is_cmd", O_is_cmd, 1'b1);
    checkOutput("cmd_status_finish", O_status, 2'b10);
    checkOutput("cmd_overrun", O_overrun, 1'b0);
    step(1);
    checkOutput("cmd_status_back_receive", O_status, 2'b01);
    checkOutput("cmd_valid_held", O_valid, 1'b1);
    I_ack = 1'b1;
    step(1);
    I_ack = 1'b0;
    checkOutput("cmd_ack_clears", O_valid, 1'b0);

    // Data byte 0x12 with rs high.
    I_rs = 1'b1;
    receive_byte(8'h12, 1'b0);
    checkOutput("data_valid", O_valid, 1'b1);
    checkOutput("data_data", O_data, 8'h12);
    checkOutput("data_is_cmd", O_is_cmd, 1'b0);
    step(3);
    checkOutput("data_hold_no_ack", O_valid, 1'b1);
    I_ack = 1'b1;
    step(1);
    I_ack = 1'b0;
    checkOutput("data_ack_clears", O_valid, 1'b0);
    I_ack = 1'b1;
    step(1);
    I_ack = 1'b0;
    checkOutput("idle_ack_ignored_valid", O_valid, 1'b0);
    checkOutput("idle_ack_ignored_data", O_data, 8'h12);

    // Overrun: 0xA5 then 0x3C without acknowledge.
    snap = overrun_count;
    receive_byte(8'hA5, 1'b0);
    checkOutput("ovr_first_data", O_data, 8'hA5);
    checkOutput("ovr_first_no_pulse", O_overrun, 1'b0);
    receive_byte(8'h3C, 1'b0);
    checkOutput("ovr_pulse", O_overrun, 1'b1);
    checkOutput("ovr_data_kept", O_data, 8'hA5);
    checkOutput("ovr_valid_kept", O_valid, 1'b1);
    step(1);
    checkOutput("ovr_pulse_ends", O_overrun, 1'b0);
    checkOutput("ovr_pulse_count", overrun_count - snap, 1);

    // Same-cycle acknowledge loads the new byte without overrun.
    snap = overrun_count;
    receive_byte(8'h5A, 1'b1);
    checkOutput("samecyc_data", O_data, 8'h5A);
    checkOutput("samecyc_valid", O_valid, 1'b1);
    checkOutput("samecyc_overrun", O_overrun, 1'b0);
    step(1);
    checkOutput("samecyc_valid_stays", O_valid, 1'b1);
    checkOutput("samecyc_no_overrun", overrun_count - snap, 0);

    // Abort after 5 bits.
    snap = frame_err_count;
    send_bits(8'hF0, 5);
    I_cs1 = 1'b1;
    step(6);
    checkOutput("abort_frame_err_count", frame_err_count - snap, 1);
    checkOutput("abort_status", O_status, 2'b00);
    checkOutput("abort_valid_kept", O_valid, 1'b1);
    checkOutput("abort_data_kept", O_data, 8'h5A);

    // Reset mid-byte, then a full 0x81 with cs still active.
    I_cs1 = 1'b0;
    step(4);
    send_bits(8'hFF, 3);
    rst = 1'b1;
    step(2);
    checkOutput("midrst_valid", O_valid, 1'b0);
    checkOutput("midrst_status", O_status, 2'b00);
    checkOutput("midrst_data", O_data, 8'h00);
    snap = frame_err_count;
    rst = 1'b0;
    step(4);
    checkOutput("postrst_status", O_status, 2'b01);
    receive_byte(8'h81, 1'b0);
    checkOutput("postrst_data", O_data, 8'h81);
    checkOutput("postrst_valid", O_valid, 1'b1);
    checkOutput("postrst_is_cmd", O_is_cmd, 1'b0);
    checkOutput("postrst_no_frame_err", frame_err_count - snap, 0);

    // Clean close on a byte boundary.
    step(2);
    snap = frame_err_count;
    I_cs1 = 1'b1;
    step(5);
    checkOutput("clean_close_status", O_status, 2'b00);
    checkOutput("clean_close_no_err", frame_err_count - snap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/lcd_receiver.md
LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 Parameter CS_ACTIVE, default 1'b0, chip-select level that marks a frame as active.
REQ-002 Parameter CMD_RS, default 1'b0, I_rs level that marks a byte as a command.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 I_cs1  input  1  serial chip select, asynchronous to clk.
REQ-006 I_rs  input  1  register select, asynchronous to clk.
REQ-007 I_sclk  input  1  serial clock, asynchronous to clk.
REQ-008 I_sid  input  1  serial data, asynchronous to clk.
REQ-009 I_ack  input  1  consumer acknowledge for the held byte.
REQ-010 O_valid  output  1  high while a received byte is held.
REQ-011 O_data  output  8  received byte.
REQ-012 O_is_cmd  output  1  1 when the held byte is a command.
REQ-013 O_status  output  2  00 READY, 01 RECEIVE, 10 FINISH.
REQ-014 O_overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-015 O_frame_err  output  1  one-cycle pulse when a frame aborts mid-byte.

Function
REQ-016 Each of I_cs1, I_rs, I_sclk and I_sid SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-017 A sclk rising edge SHALL be detected as: synchronized sclk = 1 and its registered previous value = 0.
REQ-018 Line timing: sclk high and low phases SHALL each be at least 2 clk periods; sid and rs SHALL be stable at least 3 clk periods around each sclk rising edge.
REQ-019 FSM states:
- READY (00): cs inactive.
- RECEIVE (01): cs active, byte in progress.
- FINISH (10): cs active, the last bit just completed.
REQ-020 READY->RECEIVE SHALL occur when synchronized cs equals CS_ACTIVE; the bit counter SHALL clear to 0.
REQ-021 In RECEIVE, each detected sclk rising edge SHALL shift synchronized sid into an 8-bit shift register, MSB first, and increment a 3-bit bit counter.
REQ-022 On the 8th edge (counter wraps 7->0), the state SHALL become FINISH for exactly one cycle and SHALL then return to RECEIVE when cs is still active, or to READY otherwise.
REQ-023 On the 8th edge, synchronized rs SHALL be sampled; is_cmd = (rs == CMD_RS).
REQ-024 Byte hand-off on the FINISH entry cycle:
- if O_valid = 0, or I_ack = 1 in that same cycle: load O_data and O_is_cmd, and set O_valid = 1;
- otherwise: drop the new byte, keep the held byte unchanged, and pulse O_overrun.
REQ-025 Latency: O_valid SHALL rise 4 clk cycles after the 8th I_sclk rising edge at the pin (2 sync + 1 edge detect + 1 register).
REQ-026 O_valid SHALL clear on the cycle after I_ack = 1, unless a new byte loads in that same cycle (REQ-024).
REQ-027 I_ack while O_valid = 0 SHALL be ignored.
REQ-028 cs going inactive with bit counter != 0 SHALL discard the partial byte, pulse O_frame_err, and go to READY.
REQ-029 cs going inactive with bit counter = 0 SHALL go to READY with no error.
REQ-030 Back-to-back bytes within one cs-active frame SHALL be received without gaps.
REQ-031 O_data and O_is_cmd SHALL stay stable while O_valid = 1.

Reset
REQ-032 While rst = 1, the following SHALL be cleared:
- state = READY, O_status = 00;
- O_valid = 0, O_data = 8'h00, O_is_cmd = 0;
- O_overrun = 0, O_frame_err = 0;
- shift register, bit counter and synchronizer flops to 0.
REQ-033 Reset asserted mid-byte SHALL discard the partial byte with no O_frame_err pulse.
REQ-034 After rst deasserts with cs still active, reception SHALL begin at bit 7 on the next sclk rising edge.

Verification
REQ-035 Command byte: cs active, rs = 0, shift 8'h2c -> O_valid = 1, O_data = 8'h2c, O_is_cmd = 1, 4 cycles after the 8th edge.
REQ-036 Data byte: rs = 1, shift 8'h12, ack held low -> O_data = 8'h12, O_is_cmd = 0; I_ack then clears O_valid the next cycle.
REQ-037 Overrun: 8'hA5 then 8'h3C with no ack -> O_data stays 8'hA5, and O_overrun pulses once at the FINISH of 8'h3C.
REQ-038 Same-cycle ack: I_ack asserted on the FINISH cycle of a second byte -> the second byte loads, O_valid stays 1, no overrun.
REQ-039 Abort: cs deasserted after 5 bits -> O_frame_err pulses once, status = READY, O_valid unchanged.
REQ-040 Reset: rst asserted after 3 bits, then a full 8'h81 sent -> O_data = 8'h81, no frame error.
